scoreboard_regfile: RTL
=======================

# scoreboard_regfile

Parametrised register file for the pipelined core that adds a per-register pending-write scoreboard, write-through bypass and a decode-stage stall request. It sits in the decode stage in place of the plain register file. Read ports are sampled in decode, issue is marked at decode→execute, and writeback or kill retires the entry. It generalises width, register count and read-port count. The PC register keeps its PC+8 read semantics.

## Interface
- WIDTH, 32, data width
- NREGS, 16, architectural registers (power of two, ≥4); AW = $clog2(NREGS)
- NRD, 2, read ports
- PC_REG, 15, index whose reads return pc_plus8
- MAX_INFL, 3, max in-flight writes per register (counter width CW = $clog2(MAX_INFL+1))

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous, active-high
- ra  in  NRD*AW  read addresses, port i at [i*AW +: AW]
- rd  out  NRD*WIDTH  read data, combinational
- pc_plus8  in  WIDTH  value returned for reads of PC_REG
- issue_valid  in  1  decode presents an instruction this cycle
- issue_we  in  1  that instruction writes a register
- issue_wa  in  AW  its destination
- wb_en  in  1  writeback strobe
- wb_addr  in  AW  writeback destination
- wb_data  in  WIDTH  writeback value
- kill_en  in  1  a squashed in-flight write retires without writing
- kill_addr  in  AW  its destination
- stall  out  1  decode must hold; issue not accepted
- busy  out  1  any pending counter nonzero
- err  out  1  sticky scoreboard underflow

## Operation
- Array write: on wb_en, reg[wb_addr] <= wb_data. PC_REG is never written; a wb to PC_REG is dropped.
- Read port i:
  - ra_i == PC_REG → pc_plus8.
  - Else if bypass applies (see Configuration) and wb_en && wb_addr == ra_i → wb_data.
  - Else → reg[ra_i].
- Pending counter pend[r], r ≠ PC_REG:
  - inc = issue_valid && issue_we && !stall && issue_wa == r.
  - dec = (wb_en && wb_addr == r) + (kill_en && kill_addr == r). wb and kill to the same r in one cycle count as 2.
  - pend <= pend + inc − dec.
- Hazard on read port i: ra_i ≠ PC_REG && pend[ra_i] > rel(ra_i), where rel = 1 if bypass applies to that address this cycle, else 0.
- stall = issue_valid && (any read-port hazard || (issue_we && issue_wa ≠ PC_REG && pend[issue_wa] == MAX_INFL && no dec to issue_wa this cycle)).
- Underflow: dec > pend + inc for any r. The counter clamps to 0 and err is set; err stays set until reset.
- busy = OR of all pend[r] ≠ 0.

## Timing
- Reset (synchronous): all reg = 0, all pend = 0, err = 0. In the following cycle stall = 0, busy = 0, and rd = 0 except PC_REG ports.
- Read latency: 0 cycles, combinational. Written data is visible from the array the cycle after wb_en.
- stall is combinational from the current pend values and wb/kill inputs. There is no registered stall.
- Simultaneous inc and dec on the same r leave pend unchanged. This is legal even at pend == MAX_INFL.
- Reset asserted mid-operation discards all pending state. err clears. In-flight wb arriving after reset is an underflow and sets err.
- issue_valid with issue_we = 0 never increments and never causes a full stall.

## Configuration
- REGFILE_BYPASS_EN defined:
  - Write-through enabled. A same-cycle wb to ra_i forwards wb_data and releases one pending count, so a consumer with exactly one outstanding write does not stall in the wb cycle.
- Undefined:
  - rd always comes from the array (or pc_plus8).
  - rel = 0, so the consumer stalls through the wb cycle and issues the following cycle.

## Structure
- Package scoreboard_pkg:
  - default WIDTH, NREGS, MAX_INFL constants.
  - CW derivation function.
  - typedef for the counter type.
- Sub-module pend_counter:
  - one instance per non-PC register.
  - inc/dec inputs, saturation-free add with clamp, underflow output.
  - Top level ORs the underflow outputs into err.

## Test plan
- Reset, then read r3 and r15 with pc_plus8 = 0x108 → rd = 0 and 0x108; stall = 0, busy = 0.
- Issue write to r2, then read r2 next cycle with no wb → stall = 1. Add wb r2 = 0xDEAD: with REGFILE_BYPASS_EN stall = 0 and rd = 0xDEAD in that cycle; without it, stall = 1 that cycle and rd = 0xDEAD next cycle.
- Issue r4 three times (MAX_INFL = 3), then a fourth → stall = 1. Fourth issue repeated in the same cycle as wb r4 → accepted, pend stays 3.
- Issue r5, kill r5 → pend 0, busy = 0, no write. wb r6 with pend[r6] = 0 → err = 1, stays set until reset.
- wb r15 = 0x55 → array unchanged; read r15 returns pc_plus8. Reset during pend[r1] = 2 → pend cleared, stall on r1 read = 0 next cycle.

Source files
------------

// File: rtl/scoreboard_regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Optional feature macro: REGFILE_BYPASS_EN (write-through bypass).
package scoreboard_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_NREGS    = 16;
    localparam int DEF_NRD      = 2;
    localparam int DEF_PC_REG   = 15;
    localparam int DEF_MAX_INFL = 3;

    // Counter width needed to hold 0..max_infl.
    function automatic int cw_of(input int max_infl);
        return $clog2(max_infl + 1);
    endfunction

    // Pending-write counter for the default configuration.
    typedef logic [cw_of(DEF_MAX_INFL)-1:0] pend_t;

endpackage

// File: rtl/scoreboard_regfile_if.sv
// Decode-stage bus between the pipeline and the scoreboarded register file.
// Optional feature macro: REGFILE_BYPASS_EN (affects the slave's behaviour only).
//
// Handshake: decode holds issue_valid (with issue_we/issue_wa) high; the
// instruction is accepted in a cycle where issue_valid is high and stall is
// low. stall is the inverse of ready and is combinational, so decode must keep
// its request stable until a cycle with stall low. wb_en and kill_en are
// single-cycle strobes with no back-pressure.
interface scoreboard_regfile_if
    import scoreboard_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREGS = DEF_NREGS,
    parameter int NRD   = DEF_NRD
) ();

    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]    ra;
    logic [NRD*WIDTH-1:0] rd;
    logic [WIDTH-1:0]     pc_plus8;
    logic                 issue_valid;
    logic                 issue_we;
    logic [AW-1:0]        issue_wa;
    logic                 wb_en;
    logic [AW-1:0]        wb_addr;
    logic [WIDTH-1:0]     wb_data;
    logic                 kill_en;
    logic [AW-1:0]        kill_addr;
    logic                 stall;
    logic                 busy;
    logic                 err;

    modport master (
        output ra, pc_plus8, issue_valid, issue_we, issue_wa,
               wb_en, wb_addr, wb_data, kill_en, kill_addr,
        input  rd, stall, busy, err
    );

    modport slave (
        input  ra, pc_plus8, issue_valid, issue_we, issue_wa,
               wb_en, wb_addr, wb_data, kill_en, kill_addr,
        output rd, stall, busy, err
    );

endinterface

// File: rtl/scoreboard_regfile_pend_counter.sv
// Pending-write counter for one architectural register.
// inc is at most 1, dec at most 2 (writeback plus kill). A decrement larger
// than the available count clamps to zero and flags underflow for that cycle.
module pend_counter #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc,
    input  logic [1:0]    dec,
    output logic [CW-1:0] count,
    output logic          underflow
);

    // Two guard bits: count+inc may momentarily exceed the counter range
    // when an issue lands on a full counter together with a retirement.
    logic [CW+1:0] sum;

    assign sum       = {2'b00, count} + (CW+2)'(inc);
    assign underflow = (CW+2)'(dec) > sum;

    // Counter update: add issues, subtract retirements, clamp on underflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (underflow) begin
            count <= '0;
        end else begin
            count <= CW'(sum - (CW+2)'(dec));
        end
    end

endmodule

// File: rtl/scoreboard_regfile.sv
// Register file with per-register pending-write scoreboard and decode stall.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a same-cycle
// writeback forwards to matching read ports and releases one pending count
// for the hazard check. Without it reads always come from the array.
module scoreboard_regfile
    import scoreboard_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NREGS    = DEF_NREGS,
    parameter int NRD      = DEF_NRD,
    parameter int PC_REG   = DEF_PC_REG,
    parameter int MAX_INFL = DEF_MAX_INFL
) (
    input  logic               clk,
    input  logic               reset,
    scoreboard_regfile_if.slave bus
);

    localparam int AW = $clog2(NREGS);
    localparam int CW = cw_of(MAX_INFL);

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic [WIDTH-1:0]     regs [NREGS];
    logic [CW-1:0]        pend [NREGS];
    logic [NREGS-1:0]     underflow;
    logic [NREGS-1:0]     inc;
    logic [1:0]           dec  [NREGS];
    logic [NRD*WIDTH-1:0] rd_c;
    logic                 hazard;
    logic                 full;
    logic                 stall_c;
    logic                 busy_c;
    logic                 err_q;

    // Array write; the PC slot is never written so it stays at reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
        end else if (bus.wb_en && bus.wb_addr != AW'(PC_REG)) begin
            regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Read ports and read-after-write hazard detection.
    always_comb begin
        logic [AW-1:0] a;
        logic          fwd;
        rd_c   = '0;
        hazard = 1'b0;
        a      = '0;
        fwd    = 1'b0;
        for (int i = 0; i < NRD; i++) begin
            a   = bus.ra[i*AW +: AW];
            fwd = BYPASS && bus.wb_en && (bus.wb_addr == a);
            if (a == AW'(PC_REG)) begin
                rd_c[i*WIDTH +: WIDTH] = bus.pc_plus8;
            end else begin
                rd_c[i*WIDTH +: WIDTH] = fwd ? bus.wb_data : regs[a];
                // A forwarded writeback covers one of the outstanding writes.
                if (pend[a] > CW'(fwd)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    // Destination full: no room for another in-flight write unless one
    // retires to the same register this cycle.
    always_comb begin
        full = bus.issue_we
            && (bus.issue_wa != AW'(PC_REG))
            && (pend[bus.issue_wa] == CW'(MAX_INFL))
            && !(bus.wb_en && bus.wb_addr == bus.issue_wa)
            && !(bus.kill_en && bus.kill_addr == bus.issue_wa);
        stall_c = bus.issue_valid && (hazard || full);
    end

    // Per-register increment/decrement requests.
    always_comb begin
        inc = '0;
        for (int r = 0; r < NREGS; r++) begin
            dec[r] = 2'd0;
            if (r != PC_REG) begin
                inc[r] = bus.issue_valid && bus.issue_we && !stall_c
                      && (bus.issue_wa == AW'(r));
                dec[r] = {1'b0, bus.wb_en && (bus.wb_addr == AW'(r))}
                       + {1'b0, bus.kill_en && (bus.kill_addr == AW'(r))};
            end
        end
    end

    for (genvar r = 0; r < NREGS; r++) begin : g_pend
        if (r == PC_REG) begin : g_pc
            assign pend[r]      = '0;
            assign underflow[r] = 1'b0;
        end else begin : g_cnt
            pend_counter #(.CW(CW)) u_cnt (
                .clk       (clk),
                .reset     (reset),
                .inc       (inc[r]),
                .dec       (dec[r]),
                .count     (pend[r]),
                .underflow (underflow[r])
            );
        end
    end

    // Any register with outstanding writes.
    always_comb begin
        busy_c = 1'b0;
        for (int r = 0; r < NREGS; r++) begin
            busy_c = busy_c | (pend[r] != '0);
        end
    end

    // Sticky underflow flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (|underflow) begin
            err_q <= 1'b1;
        end
    end

    assign bus.rd    = rd_c;
    assign bus.stall = stall_c;
    assign bus.busy  = busy_c;
    assign bus.err   = err_q;

endmodule
